// File: rtl/unpool.sv
// Nearest-neighbour upsampler: replicates each pooled lane and each pooled row
// pool_window_size times to rebuild a DESIGN_SIZE x DESIGN_SIZE matrix.
module unpool #(
    parameter int DWIDTH        = 8,
    parameter int DESIGN_SIZE   = 16,
    parameter int MASK_WIDTH    = 16,
    parameter int MAX_BITS_POOL = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable_unpool,
    input  logic                          in_data_available,
    output logic                          in_ready,
    input  logic [MAX_BITS_POOL-1:0]      pool_window_size,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] inp_data,
    input  logic [MASK_WIDTH-1:0]         validity_mask,
    output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
    output logic [MASK_WIDTH-1:0]         out_validity_mask,
    output logic                          out_data_available,
    output logic                          done_unpool
);

    localparam int CNT_W = $clog2(DESIGN_SIZE);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(DESIGN_SIZE - 1);

    typedef logic [MAX_BITS_POOL-1:0] win_t;
    typedef enum logic {IDLE, EMIT} state_t;

    state_t                        state, state_next;
    win_t                          rep_cnt;
    win_t                          w_lat;
    logic [CNT_W-1:0]              row_cnt;
    logic [DESIGN_SIZE*DWIDTH-1:0] row_data;
    logic [MASK_WIDTH-1:0]         row_mask;
    logic                          last_rep;
    logic                          accept;
    logic                          matrix_start;

    function automatic win_t legal_window(input win_t w);
        if (w == win_t'(1) || w == win_t'(2) || w == win_t'(4))
            return w;
        return win_t'(1);
    endfunction

    function automatic int src_lane(input int j, input win_t w);
        if (w == win_t'(4))
            return j / 4;
        if (w == win_t'(2))
            return j / 2;
        return j;
    endfunction

    function automatic logic [DESIGN_SIZE*DWIDTH-1:0] expand_data(
        input logic [DESIGN_SIZE*DWIDTH-1:0] d, input win_t w);
        logic [DESIGN_SIZE*DWIDTH-1:0] r;
        r = '0;
        for (int j = 0; j < DESIGN_SIZE; j++) begin
            int s;
            s = src_lane(j, w);
            r[j*DWIDTH +: DWIDTH] = d[s*DWIDTH +: DWIDTH];
        end
        return r;
    endfunction

    function automatic logic [MASK_WIDTH-1:0] expand_mask(
        input logic [MASK_WIDTH-1:0] m, input win_t w);
        logic [MASK_WIDTH-1:0] r;
        r = '0;
        for (int j = 0; j < MASK_WIDTH; j++)
            r[j] = m[src_lane(j, w)];
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next   = state;
        in_ready     = 1'b1;
        last_rep     = (rep_cnt == w_lat - win_t'(1));
        if (enable_unpool && state == EMIT)
            in_ready = last_rep;
        accept       = in_data_available && in_ready;
        // A row accepted here opens a new matrix: either from an idle, fresh
        // counter or straight after emitting the final row of the previous one.
        matrix_start = (state == IDLE && row_cnt == '0) ||
                       (state == EMIT && row_cnt == LAST_ROW);
        if (!enable_unpool) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_data_available) state_next = EMIT;
                EMIT:    if (last_rep && !in_data_available) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rep_cnt            <= '0;
            row_cnt            <= '0;
            w_lat              <= win_t'(1);
            row_data           <= '0;
            row_mask           <= '0;
            out_data           <= '0;
            out_validity_mask  <= '0;
            out_data_available <= 1'b0;
            done_unpool        <= 1'b0;
        end else if (!enable_unpool) begin
            rep_cnt            <= '0;
            row_cnt            <= '0;
            out_data           <= inp_data;
            out_validity_mask  <= validity_mask;
            out_data_available <= in_data_available;
            done_unpool        <= 1'b0;
        end else begin
            if (state == EMIT) begin
                out_data           <= expand_data(row_data, w_lat);
                out_validity_mask  <= expand_mask(row_mask, w_lat);
                out_data_available <= 1'b1;
                done_unpool        <= (row_cnt == LAST_ROW);
                row_cnt            <= row_cnt + CNT_W'(1);
                rep_cnt            <= last_rep ? '0 : rep_cnt + win_t'(1);
            end else begin
                out_data_available <= 1'b0;
                done_unpool        <= 1'b0;
            end
            if (accept) begin
                row_data <= inp_data;
                row_mask <= validity_mask;
                rep_cnt  <= '0;
                if (matrix_start)
                    w_lat <= legal_window(pool_window_size);
            end
        end
    end

endmodule

// File: tb/tb_unpool.sv
// Bench for unpool: a row-replication reference model checks every cycle,
// directed scenarios add literal expectations, then a long randomized run.
module tb_unpool;

    localparam int DW = 8;
    localparam int DS = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable_unpool;
    logic          in_data_available;
    logic          in_ready;
    logic [2:0]    pool_window_size;
    logic [127:0]  inp_data;
    logic [15:0]   validity_mask;
    logic [127:0]  out_data;
    logic [15:0]   out_validity_mask;
    logic          out_data_available;
    logic          done_unpool;

    unpool #(.DWIDTH(DW), .DESIGN_SIZE(DS), .MASK_WIDTH(16), .MAX_BITS_POOL(3)) dut (
        .clk(clk), .reset(reset), .enable_unpool(enable_unpool),
        .in_data_available(in_data_available), .in_ready(in_ready),
        .pool_window_size(pool_window_size), .inp_data(inp_data),
        .validity_mask(validity_mask), .out_data(out_data),
        .out_validity_mask(out_validity_mask),
        .out_data_available(out_data_available), .done_unpool(done_unpool)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the buffered row plus how many copies of it are still owed.
    int           rem = 0;
    int           cnt = 0;
    int           wl = 1;
    logic [7:0]   mrow [DS];
    logic [15:0]  mmask = '0;
    logic         started = 1'b0;
    int           vcount = 0;
    int           dcount = 0;
    logic [127:0] last_data = '0;
    logic [15:0]  last_mask = '0;

    function automatic int legal(input logic [2:0] w);
        if (w == 3'd1 || w == 3'd2 || w == 3'd4)
            return int'(w);
        return 1;
    endfunction

    always @(posedge clk) begin : model
        logic [127:0] ed;
        logic [15:0]  em;
        logic         ea, edn, cd, rdy;
        ed = '0; em = '0; ea = 1'b0; edn = 1'b0; cd = 1'b0;
        if (!reset) begin
            cd = 1'b1; rem = 0; cnt = 0; wl = 1; mmask = '0;
            for (int j = 0; j < DS; j++) mrow[j] = '0;
        end else if (!enable_unpool) begin
            ed = inp_data; em = validity_mask; ea = in_data_available;
            cd = 1'b1; rem = 0; cnt = 0;
        end else begin
            rdy = (rem <= 1);
            if (rem > 0) begin
                for (int j = 0; j < DS; j++) begin
                    ed[j*DW +: DW] = mrow[j / wl];
                    em[j] = mmask[j / wl];
                end
                ea = 1'b1; cd = 1'b1;
                edn = (cnt == DS - 1);
                cnt = (cnt + 1) % DS;
                rem = rem - 1;
            end
            if (in_data_available && rdy) begin
                if (cnt == 0) wl = legal(pool_window_size);
                for (int j = 0; j < DS; j++) mrow[j] = inp_data[j*DW +: DW];
                mmask = validity_mask;
                rem = wl;
            end
        end
        started = 1'b1;
        #1;
        chk("out_data_available", 128'(out_data_available), 128'(ea));
        chk("done_unpool", 128'(done_unpool), 128'(edn));
        if (cd) begin
            chk("out_data", out_data, ed);
            chk("out_validity_mask", 128'(out_validity_mask), 128'(em));
        end
        if (out_data_available) begin
            vcount++;
            last_data = out_data;
            last_mask = out_validity_mask;
        end
        if (done_unpool) dcount++;
    end

    always @(negedge clk) begin
        if (started)
            chk("in_ready", 128'(in_ready), 128'((!enable_unpool) || (rem <= 1)));
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic send_row(input logic [127:0] d, input logic [15:0] m);
        int   g;
        logic r;
        inp_data = d;
        validity_mask = m;
        in_data_available = 1'b1;
        g = 0;
        do begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #3;
            g++;
        end while (!r && g < 50);
        if (!r) chk("send_timeout", 128'(0), 128'(1));
    endtask

    task automatic idle(input int n);
        in_data_available = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        int           bv, bd, g;
        logic [127:0] d;
        reset = 1'b0; enable_unpool = 1'b1; in_data_available = 1'b0;
        pool_window_size = 3'd1; inp_data = '0; validity_mask = '0;
        repeat (2) tick();
        reset = 1'b1;
        chk("reset_avail", 128'(out_data_available), 128'(0));
        chk("reset_ready", 128'(in_ready), 128'(1));
        chk("reset_data", out_data, 128'(0));

        // Bypass
        enable_unpool = 1'b0; in_data_available = 1'b1;
        inp_data = 128'h100f0e0d0c0b0a090807060504030201; validity_mask = 16'hFFFF;
        tick();
        chk("bypass_data", out_data, 128'h100f0e0d0c0b0a090807060504030201);
        chk("bypass_avail", 128'(out_data_available), 128'(1));
        chk("bypass_done", 128'(done_unpool), 128'(0));
        idle(2);
        enable_unpool = 1'b1;

        // W=2 streaming
        pool_window_size = 3'd2;
        bv = vcount; bd = dcount;
        for (int r = 0; r < 8; r++)
            send_row(128'h0000_0000_0000_0000_1110_0f0e_0d0c_0b0a, 16'h00FF);
        idle(4);
        chk("w2_rows", 128'(vcount - bv), 128'(16));
        chk("w2_done", 128'(dcount - bd), 128'(1));
        chk("w2_row_data", last_data, 128'h1111_1010_0f0f_0e0e_0d0d_0c0c_0b0b_0a0a);
        chk("w2_row_mask", 128'(last_mask), 128'(16'hFFFF));

        // W=4 streaming
        pool_window_size = 3'd4;
        bv = vcount; bd = dcount;
        for (int r = 0; r < 4; r++) begin
            d = '0;
            for (int k = 0; k < 4; k++) d[k*DW +: DW] = 8'(r * 4 + k);
            send_row(d, 16'h0005);
        end
        idle(6);
        chk("w4_rows", 128'(vcount - bv), 128'(16));
        chk("w4_done", 128'(dcount - bd), 128'(1));
        chk("w4_row_data", last_data, 128'h0f0f0f0f_0e0e0e0e_0d0d0d0d_0c0c0c0c);
        chk("w4_row_mask", 128'(last_mask), 128'(16'h0F0F));

        // W=1 and illegal W=3
        for (int t = 0; t < 2; t++) begin
            pool_window_size = (t == 0) ? 3'd1 : 3'd3;
            bv = vcount; bd = dcount;
            for (int r = 0; r < 16; r++)
                send_row({$urandom, $urandom, $urandom, $urandom}, 16'(
                         $urandom));
            idle(3);
            chk("w1_rows", 128'(vcount - bv), 128'(16));
            chk("w1_done", 128'(dcount - bd), 128'(1));
        end

        // Reset in the middle of a W=2 matrix
        pool_window_size = 3'd2;
        inp_data = 128'h00000000000000000807060504030201; validity_mask = 16'h00FF;
        in_data_available = 1'b1;
        bv = vcount; bd = dcount; g = 0;
        while ((vcount - bv) < 5 && g < 100) begin tick(); g++; end
        if (g >= 100) chk("reset_wait_timeout", 128'(0), 128'(1));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("midreset_data", out_data, 128'(0));
        chk("midreset_avail", 128'(out_data_available), 128'(0));
        chk("midreset_ready", 128'(in_ready), 128'(1));
        chk("midreset_nodone", 128'(dcount - bd), 128'(0));
        idle(2);
        bv = vcount; bd = dcount;
        for (int r = 0; r < 8; r++) send_row(inp_data, 16'h00FF);
        idle(4);
        chk("after_reset_rows", 128'(vcount - bv), 128'(16));
        chk("after_reset_done", 128'(dcount - bd), 128'(1));

        // W changed mid-matrix: takes effect on the next matrix only
        bv = vcount; bd = dcount;
        for (int r = 0; r < 4; r++) send_row(128'h0403_0201, 16'h000F);
        pool_window_size = 3'd4;
        for (int r = 0; r < 4; r++) send_row(128'h0403_0201, 16'h000F);
        idle(4);
        chk("wchg_rows", 128'(vcount - bv), 128'(16));
        chk("wchg_done", 128'(dcount - bd), 128'(1));
        bv = vcount; bd = dcount;
        for (int r = 0; r < 4; r++) send_row(128'h0403_0201, 16'h000F);
        idle(6);
        chk("wchg_next_rows", 128'(vcount - bv), 128'(16));
        chk("wchg_next_done", 128'(dcount - bd), 128'(1));
        chk("wchg_next_data", last_data, 128'h04040404_03030303_02020202_01010101);

        // Randomized run
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) != 0);
            enable_unpool = ($urandom_range(0, 59) != 0);
            in_data_available = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) pool_window_size = 3'($urandom_range(0, 7));
            inp_data = {$urandom, $urandom, $urandom, $urandom};
            validity_mask = 16'($urandom);
            tick();
        end
        reset = 1'b1; enable_unpool = 1'b1;
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/unpool.md
# unpool

Nearest-neighbour upsampler, the inverse of the `pool` average-pooling stage: it accepts pooled row vectors in the same `in_data_available` / `inp_data` / `validity_mask` format and regenerates a full DESIGN_SIZE x DESIGN_SIZE matrix. Each input element is replicated `pool_window_size` times horizontally and each input row `pool_window_size` times vertically. It sits on the return path of the norm/pool datapath, feeding the systolic array or its output buffer. A single-row buffer and an `in_ready` backpressure signal absorb the 1:W rate expansion.

## Interface
- `DWIDTH`, 8, bits per element
- `DESIGN_SIZE`, 16, lanes per row and rows per matrix
- `MASK_WIDTH`, 16, validity mask width (one bit per lane; equals DESIGN_SIZE)
- `MAX_BITS_POOL`, 3, width of `pool_window_size`
- One clock; reset is synchronous and active-low.
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset
- `enable_unpool`  in  1  1 = upsample; 0 = registered bypass
- `in_data_available`  in  1  input row valid
- `in_ready`  out  1  block can accept a row this cycle
- `pool_window_size`  in  MAX_BITS_POOL  replication factor W; legal values are 1, 2 and 4
- `inp_data`  in  DESIGN_SIZE*DWIDTH  pooled row; lane j at bits [j*DWIDTH +: DWIDTH]; lanes 0..DESIGN_SIZE/W-1 are meaningful
- `validity_mask`  in  MASK_WIDTH  per-lane valid bits of the input row
- `out_data`  out  DESIGN_SIZE*DWIDTH  upsampled row, registered
- `out_validity_mask`  out  MASK_WIDTH  replicated mask, registered
- `out_data_available`  out  1  output row valid, registered
- `done_unpool`  out  1  one-cycle pulse with the last output row of a matrix

## Operation
- **Handshake:** a row is accepted on an edge where `in_data_available && in_ready`. There is no output backpressure.
- **Lane mapping:** out lane j = buffered lane j/W, using integer division. `out_validity_mask[j]` = buffered `validity_mask[j/W]`. Data passes through unmodified; no arithmetic is applied.
- **Window-size latch:** W is latched on the first accepted row of a matrix (`out_row_cnt == 0`, state IDLE). Changes to `pool_window_size` mid-matrix are ignored. Values other than 1, 2 or 4 (including 0) latch as W=1.
- **State IDLE:** `in_ready=1`, `out_data_available=0`. An accepted row loads the buffer, sets `rep_cnt=0`, and moves to EMIT.
- **State EMIT:** each cycle drives one output row and increments `rep_cnt` and `out_row_cnt`.
  - `in_ready = (rep_cnt == W-1)`.
  - At `rep_cnt == W-1` with a row accepted: the new row loads and the block stays in EMIT with `rep_cnt=0`.
  - At `rep_cnt == W-1` with no row accepted: the block returns to IDLE.
- **Row counter:** `out_row_cnt` (log2(DESIGN_SIZE) bits) counts output rows. When the row with `out_row_cnt == DESIGN_SIZE-1` is emitted, `done_unpool` is 1 for that cycle and the counter wraps to 0, which re-arms the W latch.
- **Bypass (`enable_unpool=0`):**
  - `in_ready=1`.
  - Next cycle: `out_data = inp_data`, `out_validity_mask = validity_mask`, `out_data_available = in_data_available`.
  - `done_unpool=0`; counters and state are held at IDLE/0.
- **`enable_unpool` falling mid-matrix:** pending repetitions are dropped, counters clear, and bypass takes effect from the next edge.
- **Reset (`reset=0`):** all outputs go to 0 except `in_ready`, which is 1 (IDLE). Buffer, counters and latched W clear to 0/IDLE/1. Reset mid-EMIT aborts the matrix with no `done_unpool`.

## Timing
- **Latency:** a row accepted at edge k appears on `out_data` after edge k+1 and is held for W consecutive cycles (edges k+1 .. k+W).
- **Streaming:** with `in_data_available` held high, output is gap-free at 1 row/cycle. `in_ready` duty cycle is 1 in W.
- **Matrix length:** a full matrix is DESIGN_SIZE/W accepted rows, producing DESIGN_SIZE output rows. `done_unpool` aligns with output row DESIGN_SIZE-1.
- **Bypass latency:** 1 cycle.
- **Gapped input:** if an input gap occurs (IDLE between rows), `out_data_available` drops. `out_row_cnt` is preserved, so the matrix continues.

## Test plan
- **Bypass:** `enable_unpool=0`, `inp_data` lanes = 1..16, `in_data_available=1` -> after one edge, `out_data` equals `inp_data`, `out_data_available=1`, and `done_unpool` stays 0.
- **W=2:** lanes 0..7 = 10..17, eight rows streamed with `in_data_available` held high -> each output row is 10,10,11,11,...,17,17 and is emitted twice. `in_ready` toggles 1,0. Exactly 16 valid output rows. `done_unpool` pulses on the 16th.
- **W=4:** four rows with lane 0..3 = row*4+{0..3}, `in_data_available` held high -> `in_ready` follows the pattern 1,0,0,0. Each output row is four copies of each of 4 values, each row is repeated 4 times, and `done_unpool` occurs at output 16. `validity_mask=16'h0005` replicates to `16'h0F0F`.
- **W=1 and illegal W:** with `pool_window_size=1`, then with `pool_window_size=3` -> output equals input in both cases. 16 rows produce 16 outputs, `in_ready` is constant 1, and `done_unpool` fires on row 16.
- **Reset and W change mid-matrix:** first, with W=2, drive `reset=0` after 5 output rows -> all outputs 0 and `in_ready=1` next edge; the following matrix starts at row 0. Second, with W=2, change `pool_window_size` to 4 mid-matrix -> replication stays 2 until `done_unpool`, then the next matrix uses 4.
